// File: rtl/core_types_pkg.sv
// Core-wide writeback types and PRF/ROB geometry.
// Shared by the WB arbiter and the pipelines' WB stage.
package core_types_pkg;

    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;
    localparam int LOG_PR_COUNT       = 7;
    localparam int LOG_ROB_ENTRIES    = 7;

    typedef struct packed {
        logic [31:0]                data;
        logic [LOG_PR_COUNT-1:0]    PR;
        logic [LOG_ROB_ENTRIES-1:0] ROB_index;
    } wb_req_t;

    // Low PR bits interleave physical registers across banks.
    function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(
        input logic [LOG_PR_COUNT-1:0] pr
    );
        return pr[LOG_PRF_BANK_COUNT-1:0];
    endfunction

endpackage

// File: rtl/wb_req_fifo2.sv
// Two-entry in-order FIFO holding one requester's writebacks.
// Same-cycle push and pop are allowed at any occupancy below full.
module wb_req_fifo2
    import core_types_pkg::*;
#(
    parameter type T = wb_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_req,
    input  logic pop,
    output logic head_valid,
    output T     head_req,
    output logic full
);

    T           r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;

    logic w_push;
    logic w_pop;

    assign head_valid = (r_count != 2'd0);
    assign full       = (r_count == 2'd2);
    assign head_req   = r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && head_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_req;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: per-requester FIFOs feeding one round-robin
// grant per PRF bank, registered onto bank write, bypass and ROB ports.
module prf_wb_arbiter
    import core_types_pkg::*;
#(
    parameter int REQUESTERS = 4
) (
    input  logic                                           CLK,
    input  logic                                           RST,
    input  logic [REQUESTERS-1:0]                          WB_valid,
    input  logic [REQUESTERS-1:0][31:0]                    WB_data,
    input  logic [REQUESTERS-1:0][LOG_PR_COUNT-1:0]        WB_PR,
    input  logic [REQUESTERS-1:0][LOG_ROB_ENTRIES-1:0]     WB_ROB_index,
    output logic [REQUESTERS-1:0]                          WB_ready,
    output logic [PRF_BANK_COUNT-1:0]                      bank_write_valid,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]    bank_write_PR,
    output logic [PRF_BANK_COUNT-1:0][31:0]                bank_write_data,
    output logic [PRF_BANK_COUNT-1:0][31:0]                forward_data_by_bank,
    output logic [PRF_BANK_COUNT-1:0]                      complete_valid,
    output logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0] complete_ROB_index
);

    localparam int RRW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    wb_req_t w_push_req [REQUESTERS];
    wb_req_t w_head_req [REQUESTERS];

    logic [REQUESTERS-1:0] w_head_valid;
    logic [REQUESTERS-1:0] w_full;
    logic [REQUESTERS-1:0] w_push;
    logic [REQUESTERS-1:0] w_pop;

    logic [PRF_BANK_COUNT-1:0][REQUESTERS-1:0] w_elig;
    logic [PRF_BANK_COUNT-1:0]                 w_gnt;
    logic [PRF_BANK_COUNT-1:0][RRW-1:0]        w_gnt_idx;

    logic [PRF_BANK_COUNT-1:0][RRW-1:0]             r_rr;
    logic [PRF_BANK_COUNT-1:0]                      r_valid;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]    r_pr;
    logic [PRF_BANK_COUNT-1:0][31:0]                r_data;
    logic [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0] r_rob;

    // First eligible requester at or after ptr, wrapping; MSB = found.
    function automatic logic [RRW:0] rr_pick(
        input logic [REQUESTERS-1:0] elig,
        input logic [RRW-1:0]        ptr
    );
        logic [RRW:0] res;
        int           idx;
        res = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % REQUESTERS;
            if (elig[idx]) begin
                res = {1'b1, RRW'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [RRW-1:0] rr_next(
        input logic [RRW-1:0] win
    );
        return RRW'((int'(win) + 1) % REQUESTERS);
    endfunction

    // Ready depends only on FIFO occupancy, never on this cycle's valid.
    assign WB_ready = ~w_full;
    assign w_push   = WB_valid & WB_ready;

    for (genvar r = 0; r < REQUESTERS; r++) begin : g_req
        assign w_push_req[r] = '{
            data:      WB_data[r],
            PR:        WB_PR[r],
            ROB_index: WB_ROB_index[r]
        };

        wb_req_fifo2 #(
            .T(wb_req_t)
        ) u_fifo (
            .clk        (CLK),
            .rst        (RST),
            .push       (w_push[r]),
            .push_req   (w_push_req[r]),
            .pop        (w_pop[r]),
            .head_valid (w_head_valid[r]),
            .head_req   (w_head_req[r]),
            .full       (w_full[r])
        );
    end

    always_comb begin
        w_elig    = '0;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_pop     = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int r = 0; r < REQUESTERS; r++) begin
                w_elig[b][r] = w_head_valid[r] &&
                    (pr_bank(w_head_req[r].PR) ==
                     LOG_PRF_BANK_COUNT'(b));
            end
            {w_gnt[b], w_gnt_idx[b]} = rr_pick(w_elig[b], r_rr[b]);
            // A head names one bank, so at most one bank pops it.
            if (w_gnt[b]) begin
                w_pop[w_gnt_idx[b]] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr    <= '0;
            r_valid <= '0;
            r_pr    <= '0;
            r_data  <= '0;
            r_rob   <= '0;
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                r_valid[b] <= w_gnt[b];
                if (w_gnt[b]) begin
                    r_rr[b]   <= rr_next(w_gnt_idx[b]);
                    r_pr[b]   <= w_head_req[w_gnt_idx[b]].PR;
                    r_data[b] <= w_head_req[w_gnt_idx[b]].data;
                    r_rob[b]  <= w_head_req[w_gnt_idx[b]].ROB_index;
                end
            end
        end
    end

    assign bank_write_valid     = r_valid;
    assign bank_write_PR        = r_pr;
    assign bank_write_data      = r_data;
    assign forward_data_by_bank = r_data;
    assign complete_valid       = r_valid;
    assign complete_ROB_index   = r_rob;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed and randomized bench for prf_wb_arbiter with a
// per-requester queue scoreboard.
module tb_prf_wb_arbiter;
    import core_types_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic [3:0]       WB_valid;
    logic [3:0][31:0] WB_data;
    logic [3:0][6:0]  WB_PR;
    logic [3:0][6:0]  WB_ROB_index;
    logic [3:0]       WB_ready;
    logic [3:0]       bank_write_valid;
    logic [3:0][6:0]  bank_write_PR;
    logic [3:0][31:0] bank_write_data;
    logic [3:0][31:0] forward_data_by_bank;
    logic [3:0]       complete_valid;
    logic [3:0][6:0]  complete_ROB_index;

    prf_wb_arbiter #(.REQUESTERS(4)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .WB_valid             (WB_valid),
        .WB_data              (WB_data),
        .WB_PR                (WB_PR),
        .WB_ROB_index         (WB_ROB_index),
        .WB_ready             (WB_ready),
        .bank_write_valid     (bank_write_valid),
        .bank_write_PR        (bank_write_PR),
        .bank_write_data      (bank_write_data),
        .forward_data_by_bank (forward_data_by_bank),
        .complete_valid       (complete_valid),
        .complete_ROB_index   (complete_ROB_index)
    );

    always #5 CLK = ~CLK;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    logic [3:0] last_acc = '0;
    wb_req_t exp_q [4][$];
    int      wr_cnt [4];
    int      total_wr = 0;
    bit      rec_b2 = 0;
    int      b2_order [$];
    int      b2_cyc [$];
    bit      r1_low_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit q_empty();
        for (int r = 0; r < 4; r++) if (exp_q[r].size() != 0) return 0;
        return 1;
    endfunction

    // One clock: log transfers, then check outputs against the queues.
    task automatic tick();
        logic [3:0] acc;
        wb_req_t    e;
        bit         hit;
        int         who;
        acc = WB_valid & WB_ready;
        for (int r = 0; r < 4; r++)
            if (acc[r]) exp_q[r].push_back('{data: WB_data[r],
                PR: WB_PR[r], ROB_index: WB_ROB_index[r]});
        last_acc = acc;
        @(posedge CLK);
        #1;
        cyc++;
        for (int b = 0; b < 4; b++) begin
            chk("cmpl_eq_wr", complete_valid[b], bank_write_valid[b]);
            if (bank_write_valid[b]) begin
                chk("bank_sel", bank_write_PR[b][1:0], b);
                chk("fwd_eq_data", forward_data_by_bank[b],
                    bank_write_data[b]);
                e = '{data: bank_write_data[b], PR: bank_write_PR[b],
                      ROB_index: complete_ROB_index[b]};
                hit = 0;
                who = -1;
                for (int r = 0; r < 4; r++)
                    if (!hit && exp_q[r].size() != 0 && exp_q[r][0] === e) begin
                        hit = 1;
                        who = r;
                    end
                chk("sb_match", hit, 1'b1);
                if (hit) begin
                    void'(exp_q[who].pop_front());
                    wr_cnt[who]++;
                end
                total_wr++;
                if (rec_b2 && b == 2) begin
                    b2_order.push_back(who);
                    b2_cyc.push_back(cyc);
                end
            end
        end
        for (int r = 0; r < 4; r++)
            chk("ready_occ", WB_ready[r], exp_q[r].size() != 2);
        if (!WB_ready[1]) r1_low_seen = 1;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        WB_valid = '0;
        #1;
        chk("rst_wr_valid", bank_write_valid, 4'h0);
        chk("rst_cmpl_valid", complete_valid, 4'h0);
        chk("rst_ready", WB_ready, 4'hF);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int r = 0; r < 4; r++) begin
            exp_q[r].delete();
            wr_cnt[r] = 0;
        end
        last_acc = '0;
    endtask

    int cnt [4];
    int tgt [4];
    int g;
    int wr_before;

    initial begin
        RST = 1'b0;
        WB_valid = '0;
        WB_data = '0;
        WB_PR = '0;
        WB_ROB_index = '0;
        @(negedge CLK);
        do_reset();
        chk("rst_pr", bank_write_PR, '0);
        chk("rst_data", bank_write_data, '0);
        chk("rst_rob", complete_ROB_index, '0);

        // Single write
        WB_valid = 4'b0001;
        WB_PR[0] = 7'h05;
        WB_data[0] = 32'hDEADBEEF;
        WB_ROB_index[0] = 7'd3;
        tick();
        WB_valid = '0;
        chk("single_t1_valid", bank_write_valid, 4'h0);
        tick();
        chk("single_valid", bank_write_valid, 4'b0010);
        chk("single_pr", bank_write_PR[1], 7'h05);
        chk("single_fwd", forward_data_by_bank[1], 32'hDEADBEEF);
        chk("single_cmpl", complete_valid, 4'b0010);
        chk("single_rob", complete_ROB_index[1], 7'd3);
        tick();
        chk("single_after", bank_write_valid, 4'h0);

        // Parallel banks
        for (int r = 0; r < 4; r++) begin
            WB_PR[r] = 7'(4 + r);
            WB_data[r] = $urandom;
            WB_ROB_index[r] = 7'(10 + r);
        end
        WB_valid = 4'hF;
        tick();
        WB_valid = '0;
        tick();
        chk("par_valid", bank_write_valid, 4'hF);
        chk("par_cmpl", complete_valid, 4'hF);
        tick();

        // Round-robin contention on bank 2
        do_reset();
        rec_b2 = 1;
        b2_order.delete();
        b2_cyc.delete();
        for (int r = 0; r < 4; r++) cnt[r] = 0;
        for (g = 0; g < 60; g++) begin
            for (int r = 0; r < 4; r++) begin
                WB_valid[r] = (cnt[r] < 4);
                WB_PR[r] = 7'(((r * 4 + cnt[r]) * 4) + 2);
                WB_data[r] = 32'(32'h100 * r + cnt[r]);
                WB_ROB_index[r] = 7'(r * 4 + cnt[r]);
            end
            if (WB_valid == 4'h0 && q_empty()) break;
            tick();
            for (int r = 0; r < 4; r++) if (last_acc[r]) cnt[r]++;
        end
        rec_b2 = 0;
        chk("rr_drained", q_empty(), 1'b1);
        chk("rr_count", b2_order.size(), 16);
        if (b2_order.size() == 16) begin
            for (int i = 0; i < 16; i++)
                chk("rr_order", b2_order[i], i % 4);
            chk("rr_span", b2_cyc[15] - b2_cyc[0], 15);
        end

        // Backpressure: r1 three writes vs r0 stream, all bank 0
        do_reset();
        r1_low_seen = 0;
        cnt[0] = 0; cnt[1] = 0; tgt[0] = 8; tgt[1] = 3;
        WB_valid = '0;
        for (g = 0; g < 60; g++) begin
            for (int r = 0; r < 2; r++) begin
                WB_valid[r] = (cnt[r] < tgt[r]);
                WB_PR[r] = 7'(4 * (8 * (r + 1) + cnt[r]));
                WB_data[r] = 32'(32'hB000 + 32'h100 * r + cnt[r]);
                WB_ROB_index[r] = 7'(20 + 10 * r + cnt[r]);
            end
            if (WB_valid == 4'h0 && q_empty()) break;
            tick();
            for (int r = 0; r < 2; r++) if (last_acc[r]) cnt[r]++;
        end
        chk("bp_drained", q_empty(), 1'b1);
        chk("bp_r1_low", r1_low_seen, 1'b1);
        chk("bp_r1_writes", wr_cnt[1], 3);
        chk("bp_r0_writes", wr_cnt[0], 8);

        // Reset mid-operation
        do_reset();
        for (int r = 0; r < 4; r++) begin
            WB_PR[r] = 7'(4 * (r + 1) + 3);
            WB_data[r] = $urandom;
            WB_ROB_index[r] = 7'(r);
        end
        WB_valid = 4'hF;
        tick();
        tick();
        chk("mid_pending", q_empty(), 1'b0);
        do_reset();
        wr_before = total_wr;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_no_stale", total_wr - wr_before, 0);

        // Random soak
        do_reset();
        WB_valid = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!WB_valid[r] || last_acc[r]) begin
                    WB_valid[r] = ($urandom_range(0, 3) != 0);
                    WB_PR[r] = 7'($urandom);
                    WB_data[r] = $urandom;
                    WB_ROB_index[r] = 7'($urandom);
                end
            end
            tick();
        end
        WB_valid = '0;
        for (g = 0; g < 100; g++) begin
            if (q_empty()) break;
            tick();
        end
        chk("soak_drained", q_empty(), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prf_wb_arbiter.md
# prf_wb_arbiter

- Collects writeback requests from REQUESTERS execution pipelines (ALU reg/imm, LDU, mul/div) on the valid/ready WB interface.
- Buffers each requester in a 2-entry FIFO.
- Per PRF bank, round-robin arbitrates the FIFO heads that target that bank, giving one registered write per bank per cycle.
- Each grant drives the PRF bank write port, the per-bank forward data broadcast consumed by pipeline operand bypass, and a ROB completion.

## Interface
Parameters:
- REQUESTERS, 4: number of WB source pipelines.
- PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT, LOG_ROB_ENTRIES: fixed, from core_types_pkg (4, 2, 7, 7).

Ports:
- CLK  input  1: single clock, rising edge.
- RST  input  1: reset, asynchronous, active-high.
- WB_valid  input  [REQUESTERS-1:0]: requester r presents a writeback.
- WB_data  input  [REQUESTERS-1:0][31:0]: result value.
- WB_PR  input  [REQUESTERS-1:0][LOG_PR_COUNT-1:0]: destination PR; bits [LOG_PRF_BANK_COUNT-1:0] select the bank.
- WB_ROB_index  input  [REQUESTERS-1:0][LOG_ROB_ENTRIES-1:0]: ROB entry to complete.
- WB_ready  output  [REQUESTERS-1:0]: FIFO r can accept this cycle.
- bank_write_valid  output  [PRF_BANK_COUNT-1:0]: registered PRF bank write enable.
- bank_write_PR  output  [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]: registered write PR.
- bank_write_data  output  [PRF_BANK_COUNT-1:0][31:0]: registered write data.
- forward_data_by_bank  output  [PRF_BANK_COUNT-1:0][31:0]: same value as bank_write_data, for bypass.
- complete_valid  output  [PRF_BANK_COUNT-1:0]: ROB completion strobe.
- complete_ROB_index  output  [PRF_BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0]: ROB index being completed.

## Operation
- **Transfer:** a request transfers when WB_valid[r] & WB_ready[r] in the same cycle. The requester holds valid and payload stable until that transfer.
- **WB_ready:** WB_ready[r] = (FIFO r count != 2). It is a function of registered state only, with no combinational path from WB_valid or the arbitration.
- **FIFO:** 2 entries, in order; push and pop may happen in the same cycle. A push while full cannot occur because ready is low.
- **Eligibility:** a FIFO head is eligible for bank b when the FIFO is non-empty and head PR[1:0] == b. Only heads arbitrate; there is no bypass around a blocked head.
- **Per-bank round-robin:** pointer rr[b] has width $clog2(REQUESTERS). The winner is the first eligible requester at or after rr[b], wrapping modulo REQUESTERS.
  - On a grant, rr[b] <= winner+1 mod REQUESTERS.
  - With no eligible requester, rr[b] holds.
- **Pop:** a granted FIFO pops that cycle. A requester targets at most one bank, so it receives at most one grant per cycle.
- **Registered outputs:** each granted bank registers valid, PR, data and ROB index into bank_write_*, forward_data_by_bank, complete_*.
  - A bank with no grant drives its valid bits to 0 the next cycle.
  - PR, data, forward and ROB index hold their last values.
- **PR 0:** PR 0 writes are forwarded like any other PR; the PRF ignores them. The arbiter does not special-case PR 0.
- **Reset (RST high):** asynchronously clears all FIFOs (count 0) and rr[*]. All output registers become 0. WB_ready reads all ones, since it is combinational on count 0. Any in-flight entries are discarded.

## Timing
- **Latency:** accept in cycle t → earliest bank_write_valid/complete_valid in cycle t+2.
  - t+1: the entry is the FIFO head and arbitrates.
  - t+2: the registered output is visible.
- **Throughput:** one write per bank per cycle. A requester streaming to a bank it alone uses sustains 1 per cycle with WB_ready held high.
- **Contention:** N requesters on one bank each receive a grant within N cycles of becoming head. There is no starvation.
- **Simultaneous events:** push and pop in the same cycle at count 1 keeps count 1. At count 2, pop frees the slot and ready rises the next cycle.
- **Backpressure:** a full FIFO whose head loses arbitration keeps WB_ready low until it is granted.

## Structure
- core_types_pkg gains typedef wb_req_t: packed struct {data[31:0], PR, ROB_index}, shared with the pipelines' WB stage.
- Sub-module wb_req_fifo2: parameterized 2-entry FIFO of wb_req_t.
  - Ports: push, push_req, pop, head_valid, head_req, full.
  - Reset: async active-high.
  - Instantiated REQUESTERS times.
- Round-robin pick is a function inside prf_wb_arbiter, one copy per bank.

## Test plan
- **Single write:** reset, then r0 sends PR 0x05, data 0xDEADBEEF, ROB 3 at t.
  - bank_write_valid[1]=1, PR 0x05, forward_data_by_bank[1]=0xDEADBEEF, complete ROB 3 at t+2.
  - All other banks' valid bits stay 0.
- **Parallel banks:** r0..r3 each send one request at the same cycle, to PR 0x04, 0x05, 0x06, 0x07 (banks 0-3).
  - All four banks write in the same cycle, t+2.
- **Round-robin contention:** r0..r3 each stream 4 writes to bank 2 (PRs 0x02, 0x06, ...).
  - Grants go r0, r1, r2, r3 repeating, 16 writes over 16 cycles.
  - WB_ready toggles per FIFO occupancy; no lost or duplicated PR.
- **Backpressure:** r1 sends 3 back-to-back writes to bank 0 while r0 streams to bank 0.
  - r1's WB_ready drops once its FIFO holds 2.
  - All 3 of r1's writes appear in order.
- **Reset mid-operation:** RST high while FIFOs hold entries.
  - All valid outputs read 0 immediately (async) and WB_ready reads all ones.
  - No held entry is written after RST falls.
- **Random soak:** random valid/PR traffic, 10k cycles.
  - Scoreboard: every accepted request is written exactly once.
  - Per-requester order is preserved, and bank = PR[1:0].
